// File: rtl/rf_wb_scheduler.sv
// Register-file writeback scheduler: issue scoreboard with RAW/WAW stall, a small
// load-writeback queue and a single registered write port with ALU-first priority.
module rf_wb_scheduler #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_iss_valid,
  input  logic [4:0]  i_iss_rs1,
  input  logic [4:0]  i_iss_rs2,
  input  logic [4:0]  i_iss_rd,
  output logic        o_iss_stall,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  input  logic        i_ld_valid,
  input  logic [4:0]  i_ld_rd,
  input  logic [31:0] i_ld_data,
  output logic        o_ld_ready,
  output logic        o_rf_wr,
  output logic [4:0]  o_rf_rd,
  output logic [31:0] o_rf_wdata,
  output logic [31:0] o_pending,
  output logic [3:0]  o_lq_count,
  output logic        o_sb_err
);

  localparam int              PW        = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam logic [PW-1:0]   LAST_PTR  = PW'(LQ_DEPTH - 1);
  localparam logic [3:0]      DEPTH_CNT = 4'(LQ_DEPTH);

  logic [31:0]   r_pending;
  logic [4:0]    r_lq_rd   [LQ_DEPTH];
  logic [31:0]   r_lq_data [LQ_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [3:0]    r_count;
  logic          r_rf_wr;
  logic [4:0]    r_rf_rd;
  logic [31:0]   r_rf_wdata;
  logic          r_sb_err;

  logic          w_issue;
  logic          w_push;
  logic          w_alu_sel;
  logic          w_lq_sel;
  logic          w_sel;
  logic [4:0]    w_sel_rd;
  logic [31:0]   w_sel_data;
  logic [31:0]   w_pending_nxt;
  logic [3:0]    w_count_nxt;

  function automatic logic hazard(input logic [4:0] r, input logic [31:0] pend);
    return (r != 5'd0) && pend[r];
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // Issue hazard check against the current scoreboard
  always_comb begin
    o_iss_stall = 1'b0;
    if (i_iss_valid) begin
      o_iss_stall = hazard(i_iss_rs1, r_pending) | hazard(i_iss_rs2, r_pending) |
                    hazard(i_iss_rd, r_pending);
    end else begin
      o_iss_stall = 1'b0;
    end
  end

  // No pass-through: a full queue refuses loads even when the head pops this cycle
  assign o_ld_ready = rst_n && (r_count < DEPTH_CNT);
  assign w_issue    = i_iss_valid && !o_iss_stall && (i_iss_rd != 5'd0);
  assign w_push     = i_ld_valid && o_ld_ready && (i_ld_rd != 5'd0);
  assign w_alu_sel  = i_alu_valid && (i_alu_rd != 5'd0);
  assign w_lq_sel   = !w_alu_sel && (r_count != 4'd0);
  assign w_sel      = w_alu_sel || w_lq_sel;

  // Writeback selection: ALU first, then queue head
  always_comb begin
    w_sel_rd   = 5'd0;
    w_sel_data = 32'd0;
    if (w_alu_sel) begin
      w_sel_rd   = i_alu_rd;
      w_sel_data = i_alu_data;
    end else if (w_lq_sel) begin
      w_sel_rd   = r_lq_rd[r_rd_ptr];
      w_sel_data = r_lq_data[r_rd_ptr];
    end else begin
      w_sel_rd   = 5'd0;
      w_sel_data = 32'd0;
    end
  end

  // Scoreboard update: clear on selected write, then set on issue so set wins
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_sel) begin
      w_pending_nxt[w_sel_rd] = 1'b0;
    end else begin
      w_pending_nxt = r_pending;
    end
    if (w_issue) begin
      w_pending_nxt[i_iss_rd] = 1'b1;
    end else begin
      w_pending_nxt[0] = 1'b0;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // Queue occupancy next value
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_lq_sel})
      2'b10:   w_count_nxt = r_count + 4'd1;
      2'b01:   w_count_nxt = r_count - 4'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Control state, write port and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending  <= 32'd0;
      r_wr_ptr   <= {PW{1'b0}};
      r_rd_ptr   <= {PW{1'b0}};
      r_count    <= 4'd0;
      r_rf_wr    <= 1'b0;
      r_rf_rd    <= 5'd0;
      r_rf_wdata <= 32'd0;
      r_sb_err   <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_count   <= w_count_nxt;
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_lq_sel) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_rf_wr <= w_sel;
      if (w_sel) begin
        r_rf_rd    <= w_sel_rd;
        r_rf_wdata <= w_sel_data;
      end
      if (w_sel && !r_pending[w_sel_rd]) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  // Queue storage; writes are already gated off during reset through o_ld_ready
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_lq_rd[r_wr_ptr]   <= i_ld_rd;
      r_lq_data[r_wr_ptr] <= i_ld_data;
    end
  end

  assign o_rf_wr    = r_rf_wr;
  assign o_rf_rd    = r_rf_rd;
  assign o_rf_wdata = r_rf_wdata;
  assign o_pending  = r_pending;
  assign o_lq_count = r_count;
  assign o_sb_err   = r_sb_err;

endmodule
